// File: rtl/pipe_register.sv
// Elastic pipeline register: DEPTH stages, each with a valid bit and data,
// valid/ready handshakes at both ends, with bubble collapsing and a synchronous flush.
module pipe_register #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] free;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] data_d   [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             in_fire;

  // free[i]: stage i can take a new item this cycle (empty, or its item moves on).
  always_comb begin
    logic free_down;
    free_down = out_ready;
    free      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free[i]   = ~valid_q[i] | free_down;
      free_down = free[i];
    end
  end

  assign in_ready = free[0] & ~flush;
  assign in_fire  = in_valid & in_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
    if (gi == 0) begin : g_head
      assign src_valid[gi] = in_fire;
      assign src_data[gi]  = in_data;
    end else begin : g_body
      assign src_valid[gi] = valid_q[gi-1];
      assign src_data[gi]  = data_q[gi-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (free[i]) begin
          valid_d[i] = src_valid[i];
          // Data only moves with a valid item so idle stages keep their last value.
          if (src_valid[i]) begin
            data_d[i] = src_data[i];
          end
        end
      end
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_register.sv
// Scoreboard bench for pipe_register: DEPTH 2, 1 and 8 instances share one
// stimulus stream; each has its own queue-based reference model and monitor.
module tb_pipe_register;

  localparam logic [31:0] RV = 32'hDEADBEEF;

  typedef struct {
    logic [31:0] d;
    int          t;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        started = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int D  = (gi == 0) ? 2 : ((gi == 1) ? 1 : 8);
    localparam int CW = $clog2(D + 1);

    logic          in_ready_w;
    logic          out_valid_w;
    logic [31:0]   out_data_w;
    logic [CW-1:0] count_w;
    logic [3:0]    count_ext;

    assign count_ext = 4'(count_w);

    pipe_register #(.WIDTH(32), .DEPTH(D), .RESET_VALUE(RV)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready_w),
      .out_valid (out_valid_w),
      .out_data  (out_data_w),
      .out_ready (out_ready),
      .count     (count_w)
    );

    item_t q[$];
    int    ncyc = 0;
    bit    was_reset = 1'b0;

    // Model: head item shows up D edges after acceptance; blocked only when all D slots full.
    always @(negedge clk) begin
      if (started) begin
        logic exp_valid;
        logic exp_ready;
        exp_valid = (q.size() > 0) && (ncyc >= q[0].t);
        exp_ready = !flush && !((q.size() == D) && !out_ready);

        chk("out_valid", gi, 64'(out_valid_w), 64'(exp_valid));
        if (exp_valid) chk("out_data", gi, 64'(out_data_w), 64'(q[0].d));
        if (was_reset) chk("reset_data", gi, 64'(out_data_w), 64'(RV));
        chk("count", gi, 64'(count_ext), 64'(q.size()));
        chk("in_ready", gi, 64'(in_ready_w), 64'(exp_ready));
        if (exp_valid && out_ready && reset)
          $display("inst%0d D=%0d t=%0t deliver %08h", gi, D, $time, q[0].d);

        was_reset = !reset;
        if (!reset) begin
          q.delete();
        end else begin
          if (exp_valid && out_ready) void'(q.pop_front());
          if (flush) q.delete();
          else if (in_valid && exp_ready) q.push_back('{d: in_data, t: ncyc + D});
        end
        ncyc++;
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [31:0] d, input logic ordy);
    reset     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    started = 1'b1;

    // Latency: three back-to-back pushes with the consumer always ready.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure: A, B, then C held while the consumer stalls.
    cyc(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'hC, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Full pass-through: fill, then 4 cycles of simultaneous in and out.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 32'h200 + 32'(i), 1'b1);

    // Flush while full and draining.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 32'h300 + 32'(i), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h3FF, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Randomised traffic with occasional flush and mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 149) != 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) != 0),
          $urandom,
          (i % 400 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_register.md
PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits, SHALL be legal for values 1..64.
REQ-002 Parameter DEPTH, default 2, number of pipeline stages, SHALL be legal for values 1..8.
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into every stage data register on reset.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-006 flush  input  1  synchronous clear of all stage valid bits.
REQ-007 in_valid  input  1  producer offers in_data this cycle.
REQ-008 in_data  input  WIDTH  producer data.
REQ-009 in_ready  output  1  pipeline accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid item.
REQ-011 out_data  output  WIDTH  data of the last stage.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 count  output  clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

Function
REQ-014 Stages SHALL be numbered 0 (input side) to DEPTH-1 (output side), each holding a valid bit and a WIDTH-bit data register.
REQ-015 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer where out_valid=1 and out_ready=1.
REQ-016 Stage DEPTH-1 SHALL advance when out_ready=1 or it is empty; stage i<DEPTH-1 SHALL advance when stage i+1 is empty or advancing.
REQ-017 in_ready SHALL equal (stage 0 empty or stage 0 advancing) and not flush; it is combinational from out_ready.
REQ-018 An advancing valid stage i SHALL pass valid+data to stage i+1; stage 0 SHALL load in_data and valid on input transfer; a stage losing its item without refill SHALL clear valid.
REQ-019 A stage data register SHALL load only when it receives a valid item; otherwise it holds its value.
REQ-020 Bubbles SHALL collapse: an item advances into any empty downstream stage each cycle.
REQ-021 Latency SHALL be DEPTH cycles from input transfer to out_valid=1 with no backpressure; throughput one item per cycle sustained.
REQ-022 Items SHALL leave in acceptance order, none lost or duplicated.
REQ-023 out_valid SHALL equal stage DEPTH-1 valid; out_data SHALL equal stage DEPTH-1 data.
REQ-024 count SHALL equal the registered number of valid stages.
REQ-025 Full (count=DEPTH) with out_ready=0: in_ready=0, all state held.
REQ-026 Full with out_ready=1: simultaneous input and output transfer, count unchanged.
REQ-027 flush=1: output transfer in that cycle SHALL still count as delivered; next cycle all valid bits=0, count=0; data registers hold; no input accepted.
REQ-028 reset overrides flush and all handshakes.

Reset
REQ-029 With reset=0 at a rising edge, all valid bits SHALL clear and all data registers SHALL load RESET_VALUE.
REQ-030 Following reset: out_valid=0, out_data=RESET_VALUE, count=0, in_ready=1 (when flush=0).
REQ-031 Reset mid-stream SHALL discard all in-flight items; no item accepted in the reset cycle appears at the output.

Verification (WIDTH=32, DEPTH=2, RESET_VALUE=32'hDEADBEEF unless stated)
REQ-032 Reset: reset=0 one cycle -> out_valid=0, out_data=32'hDEADBEEF, count=0, in_ready=1.
REQ-033 Latency: out_ready=1, push 32'h1,2,3 on consecutive cycles -> out_valid rises 2 cycles after first push, out_data 1,2,3 on consecutive cycles.
REQ-034 Backpressure: out_ready=0, push A,B,C -> A,B accepted, count=2, in_ready=0, C held; raise out_ready -> A,B,C delivered in order, none lost.
REQ-035 Full pass-through: count=2, in_valid=1, out_ready=1 for 4 cycles -> 4 in, 4 out, count stays 2.
REQ-036 Flush: count=2, out_ready=1, flush=1 one cycle -> head delivered that cycle, next cycle count=0, out_valid=0, in_ready=1.
REQ-037 DEPTH=1 and DEPTH=8 builds: repeat REQ-033/REQ-034 -> latency 1 and 8 respectively, full at count 1 and 8.
